// File: rtl/test_pattern_gen.sv
// rtl/test_pattern_gen.sv - command-driven UART test pattern generator (inc/dec/const/LFSR)
module test_pattern_gen #(
  parameter int                 DATA_W     = 8,
  parameter int                 GAP_CYCLES = 100,
  parameter int                 RX_TIMEOUT = 50000,
  parameter logic [DATA_W-1:0]  LFSR_TAPS  = 8'hB8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] idata,
  input  logic              newRxData,
  input  logic              txBusy,
  output logic [DATA_W-1:0] odata,
  output logic              oe,
  output logic              busy,
  output logic              done
);

  localparam int TW = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_SEED,
    S_GET_CNT,
    S_EMIT,
    S_GAP,
    S_WAIT_TX
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] sent_q, sent_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [15:0]       gap_q, gap_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              done_q, done_d;

  function automatic logic [DATA_W-1:0] next_word(input logic [1:0] mode,
                                                  input logic [DATA_W-1:0] cur);
    case (mode)
      2'd0:    next_word = cur + DATA_W'(1);
      2'd1:    next_word = cur - DATA_W'(1);
      2'd2:    next_word = cur;
      default: next_word = {cur[DATA_W-2:0], ^(cur & LFSR_TAPS)};
    endcase
  endfunction

  // State and datapath registers; reset silences all outputs at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      seed_q  <= '0;
      n_q     <= '0;
      cur_q   <= '0;
      sent_q  <= '0;
      odata_q <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      n_q     <= n_d;
      cur_q   <= cur_d;
      sent_q  <= sent_d;
      odata_q <= odata_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

  // Command parsing, emission sequencing, abort and timeout decisions.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    n_d     = n_q;
    cur_d   = cur_q;
    sent_d  = sent_q;
    odata_d = odata_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (newRxData) begin
          mode_d  = idata[1:0];
          tmo_d   = '0;
          state_d = S_GET_SEED;
        end
      end

      S_GET_SEED: begin
        if (newRxData) begin
          seed_d  = idata;
          tmo_d   = '0;
          state_d = S_GET_CNT;
        end else if (tmo_q == TW'(RX_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_GET_CNT: begin
        if (newRxData) begin
          n_d    = idata;
          sent_d = '0;
          // An all-zero LFSR state would lock up, so it is replaced by 1.
          cur_d  = (mode_q == 2'd3 && seed_q == '0) ? DATA_W'(1) : seed_q;
          if (idata == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_EMIT;
          end
        end else if (tmo_q == TW'(RX_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_EMIT: begin
        odata_d = cur_q;
        sent_d  = sent_q + DATA_W'(1);
        gap_d   = '0;
        if (newRxData) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (newRxData) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gap_q == 16'(GAP_CYCLES - 1)) begin
          state_d = S_WAIT_TX;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end

      S_WAIT_TX: begin
        if (newRxData) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (!txBusy) begin
          if (sent_q == n_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cur_d   = next_word(mode_q, cur_q);
            state_d = S_EMIT;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // The word is presented alongside its strobe and held afterwards.
  assign oe    = (state_q == S_EMIT);
  assign odata = oe ? cur_q : odata_q;
  assign busy  = (state_q == S_EMIT) || (state_q == S_GAP) || (state_q == S_WAIT_TX);
  assign done  = done_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// tb/tb_test_pattern_gen.sv - directed self-checking bench for test_pattern_gen
module tb_test_pattern_gen;

  localparam int RX_TO = 300;

  logic       clk;
  logic       rst;
  logic [7:0] idata;
  logic       newRxData;
  logic       txBusy;
  logic [7:0] odata;
  logic       oe;
  logic       busy;
  logic       done;

  test_pattern_gen #(
    .DATA_W(8), .GAP_CYCLES(100), .RX_TIMEOUT(RX_TO), .LFSR_TAPS(8'hB8)
  ) dut (
    .clk(clk), .rst(rst), .idata(idata), .newRxData(newRxData), .txBusy(txBusy),
    .odata(odata), .oe(oe), .busy(busy), .done(done)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         both_hi  = 0;
  logic [7:0] oe_data[$];
  int         oe_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp for spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe away from the active edge.
  always @(negedge clk) begin
    if (oe) begin
      oe_data.push_back(odata);
      oe_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (oe && done) both_hi = both_hi + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    @(posedge clk);
    #1 idata = w;
    newRxData = 1'b1;
    @(posedge clk);
    #1 newRxData = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] m, input logic [7:0] s, input logic [7:0] n);
    send_word(m);
    send_word(s);
    send_word(n);
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    int k = 0;
    while (done_cnt == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_done"}, done_cnt - base, 1);
  endtask

  task automatic wait_oe(input string tag, input int n, input int budget);
    int k = 0;
    while (oe_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_oe_seen"}, oe_data.size(), n);
  endtask

  task automatic check_seq(input string tag, input int n, input logic [79:0] vals);
    logic [31:0] got;
    check_eq({tag, "_count"}, oe_data.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < oe_data.size()) ? {24'h0, oe_data[i]} : 32'hFFFF_FFFF;
      check_eq($sformatf("%s_w%0d", tag, i), got, {24'h0, vals[8*(n-1-i) +: 8]});
    end
  endtask

  task automatic clear_log();
    oe_data.delete();
    oe_cyc.delete();
  endtask

  initial begin
    int base;
    int fall;

    rst = 1'b1;
    idata = '0;
    newRxData = 1'b0;
    txBusy = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_odata", odata, 0);
    check_eq("rst_oe", oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Incrementing pattern across the wrap point, with exact spacing.
    clear_log();
    base = done_cnt;
    send_cmd(8'h00, 8'hFE, 8'h03);
    wait_oe("inc", 1, 20);
    repeat (5) @(negedge clk);
    check_eq("inc_busy_gap", busy, 1);
    wait_done("inc", base, 1000);
    check_seq("inc", 3, 80'hFEFF00);
    check_eq("inc_space1", oe_cyc[1] - oe_cyc[0], 102);
    check_eq("inc_space2", oe_cyc[2] - oe_cyc[1], 102);
    check_eq("inc_done_lat", done_cyc - oe_cyc[2], 102);
    @(negedge clk);
    check_eq("inc_busy_after", busy, 0);
    check_eq("inc_odata_hold", odata, 8'h00);

    // LFSR with zero seed, then decrement across zero.
    clear_log();
    base = done_cnt;
    send_cmd(8'h03, 8'h00, 8'h05);
    wait_done("lfsr", base, 1000);
    check_seq("lfsr", 5, 80'h0102040811);

    clear_log();
    base = done_cnt;
    send_cmd(8'hFD, 8'h01, 8'h03);
    wait_done("dec", base, 1000);
    check_seq("dec", 3, 80'h0100FF);

    // Back-pressure holds the second word until txBusy falls.
    clear_log();
    base = done_cnt;
    send_cmd(8'h00, 8'h30, 8'h02);
    wait_oe("bp", 1, 20);
    txBusy = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    check_eq("bp_held", oe_data.size(), 1);
    txBusy = 1'b0;
    fall = cyc;
    wait_done("bp", base, 500);
    check_seq("bp", 2, 80'h3031);
    check_eq("bp_release", oe_cyc[1] - fall, 1);

    // Zero count: one done, no strobe.
    clear_log();
    base = done_cnt;
    send_cmd(8'h00, 8'h05, 8'h00);
    repeat (5) @(negedge clk);
    check_eq("n0_done", done_cnt - base, 1);
    check_eq("n0_oe", oe_data.size(), 0);

    // Partial command times out silently; next command parses cleanly.
    base = done_cnt;
    send_word(8'h00);
    repeat (RX_TO + 10) @(negedge clk);
    check_eq("tmo_no_done", done_cnt - base, 0);
    send_cmd(8'h00, 8'h10, 8'h01);
    wait_done("tmo_next", base, 500);
    check_seq("tmo_next", 1, 80'h10);

    // Abort during the third gap.
    clear_log();
    base = done_cnt;
    send_cmd(8'h02, 8'hA5, 8'h0A);
    wait_oe("abort", 3, 1000);
    repeat (10) @(negedge clk);
    send_word(8'h77);
    repeat (3) @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done_cnt - base, 1);
    repeat (300) @(negedge clk);
    check_seq("abort", 3, 80'hA5A5A5);
    clear_log();
    base = done_cnt;
    send_cmd(8'h01, 8'h05, 8'h02);
    wait_done("abort_next", base, 500);
    check_seq("abort_next", 2, 80'h0504);

    // Asynchronous reset while waiting on the transmitter.
    clear_log();
    send_cmd(8'h00, 8'h40, 8'h03);
    wait_oe("rstrun", 1, 20);
    txBusy = 1'b1;
    repeat (150) @(negedge clk);
    base = done_cnt;
    #3 rst = 1'b1;
    #1;
    check_eq("rstrun_odata", odata, 0);
    check_eq("rstrun_oe", oe, 0);
    check_eq("rstrun_busy", busy, 0);
    check_eq("rstrun_done", done, 0);
    txBusy = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("rstrun_no_done", done_cnt - base, 0);
    check_eq("rstrun_no_oe", oe_data.size(), 1);

    check_eq("oe_done_overlap", both_hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
